// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit instructions from four byte reads
// and hands {inst, pc+4} to decode through a valid/stall handshake.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        mem_re_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_data_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam logic [2:0] S_F0   = 3'd0;
  localparam logic [2:0] S_F1   = 3'd1;
  localparam logic [2:0] S_F2   = 3'd2;
  localparam logic [2:0] S_F3   = 3'd3;
  localparam logic [2:0] S_LAST = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [7:0]  b0, b1, b2;
  logic [31:0] hold_inst, hold_pc;
  logic [31:0] pc_next4;
  logic [31:0] inst_full;
  logic        out_free;

  assign pc_next4  = pc + 32'd4;
  assign inst_full = {mem_data_i, b2, b1, b0};
  assign out_free  = ~valid_o | ~stall_i;

  // F0..F3 encode the byte offset in their low bits, so the address is pc+k.
  assign mem_re_o   = ~rst & ~state[2];
  assign mem_addr_o = rst ? 32'd0 : pc + {30'd0, state[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_F0;
      pc      <= RESET_PC;
      valid_o <= 1'b0;
      inst_o  <= 32'd0;
      pc_o    <= 32'd0;
    end else if (jump_i) begin
      state   <= S_F0;
      pc      <= jump_addr_i;
      valid_o <= 1'b0;
      inst_o  <= 32'd0;
    end else begin
      // A transfer empties the output unless a new instruction lands below.
      if (valid_o && !stall_i)
        valid_o <= 1'b0;
      case (state)
        S_F0: state <= S_F1;
        S_F1: state <= S_F2;
        S_F2: state <= S_F3;
        S_F3: state <= S_LAST;
        S_LAST: begin
          if (out_free) begin
            inst_o  <= inst_full;
            pc_o    <= pc_next4;
            valid_o <= 1'b1;
            pc      <= pc_next4;
            state   <= S_F0;
          end else begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            inst_o  <= hold_inst;
            pc_o    <= hold_pc;
            valid_o <= 1'b1;
            pc      <= pc_next4;
            state   <= S_F0;
          end
        end
        default: state <= S_F0;
      endcase
    end
  end

  // Byte and buffer storage carries no reset; control state decides validity.
  always_ff @(posedge clk) begin
    case (state)
      S_F1: b0 <= mem_data_i;
      S_F2: b1 <= mem_data_i;
      S_F3: b2 <= mem_data_i;
      S_LAST: begin
        if (!out_free) begin
          hold_inst <= inst_full;
          hold_pc   <= pc_next4;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a byte-wide instruction memory model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i = 8'h00;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .stall_i(stall_i), .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h00A0_0113;
      32'h0000_0008: mem_word = 32'h0030_8193;
      32'h0000_0100: mem_word = 32'hDEAD_BEEF;
      32'hFFFF_FFFC: mem_word = 32'h1234_5678;
      default:       mem_word = {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    mem_byte = w[8*a[1:0] +: 8];
  endfunction

  // Memory returns data the cycle after the read strobe.
  always @(posedge clk)
    mem_data_i <= mem_re_o ? mem_byte(mem_addr_o) : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (mem_re_o !== 1'b0) begin n_fail++; $display("FAIL reset_re got %b want 0", mem_re_o); end
    n_checks++; if (mem_addr_o !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_checks++; if (inst_o !== 32'd0 || pc_o !== 32'd0) begin n_fail++; $display("FAIL reset_out got inst=%h pc=%h want 0/0", inst_o, pc_o); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem_re_o !== 1'b1 || mem_addr_o !== k) begin
        n_fail++; $display("FAIL first_read%0d got re=%b addr=%h want 1/%h", k, mem_re_o, mem_addr_o, k);
      end
      step();
    end
    n_checks++; if (mem_re_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL first_last got re=%b valid=%b want 0/0", mem_re_o, valid_o); end
    step();
    n_checks++;
    if (valid_o !== 1'b1 || inst_o !== 32'h0050_0093 || pc_o !== 32'd4) begin
      n_fail++; $display("FAIL first_out got v=%b inst=%h pc=%h want 1/00500093/4", valid_o, inst_o, pc_o);
    end
    n_checks++; if (mem_re_o !== 1'b1 || mem_addr_o !== 32'd4) begin n_fail++; $display("FAIL first_next got re=%b addr=%h want 1/4", mem_re_o, mem_addr_o); end
  endtask

  task automatic test_stall_hold();
    stall_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_checks++;
      if (valid_o !== 1'b1 || inst_o !== 32'h0050_0093 || pc_o !== 32'd4) begin
        n_fail++; $display("FAIL stall_hold%0d got v=%b inst=%h pc=%h want 1/00500093/4", c, valid_o, inst_o, pc_o);
      end
      if (c >= 4) begin
        n_checks++;
        if (mem_re_o !== 1'b0) begin n_fail++; $display("FAIL stall_re%0d got %b want 0", c, mem_re_o); end
      end
    end
    stall_i = 1'b0;
    step();
    n_checks++;
    if (valid_o !== 1'b1 || inst_o !== 32'h00A0_0113 || pc_o !== 32'd8) begin
      n_fail++; $display("FAIL stall_release got v=%b inst=%h pc=%h want 1/00a00113/8", valid_o, inst_o, pc_o);
    end
    n_checks++; if (mem_re_o !== 1'b1 || mem_addr_o !== 32'd8) begin n_fail++; $display("FAIL stall_next got re=%b addr=%h want 1/8", mem_re_o, mem_addr_o); end
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b want 0", valid_o); end
  endtask

  task automatic test_jump_mid_fetch();
    step();
    n_checks++; if (mem_addr_o !== 32'd10) begin n_fail++; $display("FAIL jump_pre_addr got %h want a", mem_addr_o); end
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_0100;
    step();
    jump_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || mem_re_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL jump_issue got v=%b re=%b addr=%h want 0/1/100", valid_o, mem_re_o, mem_addr_o);
    end
    for (int c = 0; c < 5; c++) step();
    n_checks++;
    if (valid_o !== 1'b1 || inst_o !== 32'hDEAD_BEEF || pc_o !== 32'h104) begin
      n_fail++; $display("FAIL jump_out got v=%b inst=%h pc=%h want 1/deadbeef/104", valid_o, inst_o, pc_o);
    end
  endtask

  task automatic test_jump_over_stall_wrap();
    jump_i = 1'b1;
    stall_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    step();
    jump_i = 1'b0;
    stall_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || inst_o !== 32'd0) begin
      n_fail++; $display("FAIL jump_stall got v=%b inst=%h want 0/0", valid_o, inst_o);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem_re_o !== 1'b1 || mem_addr_o !== 32'hFFFF_FFFC + k) begin
        n_fail++; $display("FAIL wrap_read%0d got re=%b addr=%h want 1/%h", k, mem_re_o, mem_addr_o, 32'hFFFF_FFFC + k);
      end
      step();
    end
    step();
    n_checks++;
    if (valid_o !== 1'b1 || inst_o !== 32'h1234_5678 || pc_o !== 32'd0) begin
      n_fail++; $display("FAIL wrap_out got v=%b inst=%h pc=%h want 1/12345678/0", valid_o, inst_o, pc_o);
    end
    n_checks++; if (mem_addr_o !== 32'd0) begin n_fail++; $display("FAIL wrap_next got %h want 0", mem_addr_o); end
  endtask

  task automatic test_reset_mid_fetch();
    step();
    step();
    step();
    n_checks++; if (mem_addr_o !== 32'd3) begin n_fail++; $display("FAIL rst_pre_addr got %h want 3", mem_addr_o); end
    rst = 1'b1;
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    step();
    n_checks++;
    if (valid_o !== 1'b0 || inst_o !== 32'd0 || pc_o !== 32'd0 || mem_re_o !== 1'b0 || mem_addr_o !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid got v=%b inst=%h pc=%h re=%b addr=%h want all 0", valid_o, inst_o, pc_o, mem_re_o, mem_addr_o);
    end
    step();
    rst = 1'b0;
    jump_i = 1'b0;
    #1;
    n_checks++; if (mem_re_o !== 1'b1 || mem_addr_o !== 32'd0) begin n_fail++; $display("FAIL rst_restart got re=%b addr=%h want 1/0", mem_re_o, mem_addr_o); end
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++;
      if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_stale%0d got %b want 0", c, valid_o); end
    end
    step();
    n_checks++;
    if (valid_o !== 1'b1 || inst_o !== 32'h0050_0093 || pc_o !== 32'd4) begin
      n_fail++; $display("FAIL rst_refetch got v=%b inst=%h pc=%h want 1/00500093/4", valid_o, inst_o, pc_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_hold();
    test_jump_mid_fetch();
    test_jump_over_stall_wrap();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
